// File: rtl/seg_disp_ctrl.sv
// Six-digit 7-segment display controller: converts a nibble frame digit by digit into shadow
// registers, then commits the whole frame at once. Blinking is built only with SEG_DISP_CTRL_BLINK_EN.
module seg_disp_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [23:0] upd_val,
  input  logic [5:0]  upd_dp,
  input  logic        upd_lzs,
  input  logic [5:0]  blink_mask,
  output logic [7:0]  seg_data_0,
  output logic [7:0]  seg_data_1,
  output logic [7:0]  seg_data_2,
  output logic [7:0]  seg_data_3,
  output logic [7:0]  seg_data_4,
  output logic [7:0]  seg_data_5
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [2:0]  idx_r;
  logic [23:0] val_r;
  logic [5:0]  dp_r;
  logic        lzs_r;
  logic        lz_r;
  logic        ready_r;
  logic [7:0]  shadow_r [6];
  logic [7:0]  disp_r   [6];
  logic [7:0]  view_s   [6];
  logic        xfer_s;
  logic [3:0]  nib_s;
  logic        dp_bit_s;
  logic        suppress_s;
  logic [7:0]  code_s;

  // Active-low {dp,g,f,e,d,c,b,a}; every glyph has bit 7 high, so dp simply replaces it.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
    logic [7:0] c;
    case (nib)
      4'h0: c = 8'hC0;  4'h1: c = 8'hF9;  4'h2: c = 8'hA4;  4'h3: c = 8'hB0;
      4'h4: c = 8'h99;  4'h5: c = 8'h92;  4'h6: c = 8'h82;  4'h7: c = 8'hF8;
      4'h8: c = 8'h80;  4'h9: c = 8'h90;  4'hA: c = 8'h88;  4'hB: c = 8'h83;
      4'hC: c = 8'hC6;  4'hD: c = 8'hA1;  4'hE: c = 8'h86;  4'hF: c = 8'h8E;
      default: c = 8'hFF;
    endcase
    return {~dp, c[6:0]};
  endfunction

  assign xfer_s    = upd_valid & ready_r;
  assign upd_ready = ready_r;

  // Encode the digit currently addressed by idx, applying leading-zero suppression.
  always_comb begin
    nib_s      = val_r[{idx_r, 2'b00} +: 4];
    dp_bit_s   = dp_r[idx_r];
    suppress_s = lzs_r & lz_r & (nib_s == 4'h0) & ~dp_bit_s & (idx_r != 3'd0);
    if (suppress_s) begin
      code_s = 8'hFF;
    end else begin
      code_s = seg_encode(nib_s, dp_bit_s);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_s = CONV;
        else        state_s = IDLE;
      end
      CONV: begin
        if (idx_r == 3'd0) state_s = COMMIT;
        else               state_s = CONV;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Capture, per-digit conversion into shadow registers, and atomic commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 3'd5;
      val_r   <= 24'h000000;
      dp_r    <= 6'b000000;
      lzs_r   <= 1'b0;
      lz_r    <= 1'b1;
      ready_r <= 1'b1;
      for (int i = 0; i < 6; i++) begin
        shadow_r[i] <= 8'hFF;
        disp_r[i]   <= 8'hFF;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            val_r   <= upd_val;
            dp_r    <= upd_dp;
            lzs_r   <= upd_lzs;
            lz_r    <= 1'b1;
            idx_r   <= 3'd5;
            ready_r <= 1'b0;
          end
        end
        CONV: begin
          shadow_r[idx_r] <= code_s;
          lz_r            <= lz_r & (nib_s == 4'h0) & ~dp_bit_s;
          if (idx_r != 3'd0) idx_r <= idx_r - 3'd1;
        end
        COMMIT: begin
          for (int i = 0; i < 6; i++) disp_r[i] <= shadow_r[i];
          idx_r   <= 3'd5;
          ready_r <= 1'b1;
        end
        default: begin
          idx_r   <= 3'd5;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEG_DISP_CTRL_BLINK_EN
  localparam int HALF_RAW = CLK_FREQ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] blink_cnt_r;
  logic          blink_ph_r;

  // Free-running half-period counter; phase flips on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (blink_cnt_r == CW'(HALF - 1)) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= ~blink_ph_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  // Blanking affects only the output view, never the display registers.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      if (blink_ph_r && blink_mask[i]) view_s[i] = 8'hFF;
      else                             view_s[i] = disp_r[i];
    end
  end
`else
  logic unused_blink_s;
  assign unused_blink_s = ^blink_mask;

  // Without blinking the outputs mirror the display registers.
  always_comb begin
    for (int i = 0; i < 6; i++) view_s[i] = disp_r[i];
  end
`endif

  assign seg_data_0 = view_s[0];
  assign seg_data_1 = view_s[1];
  assign seg_data_2 = view_s[2];
  assign seg_data_3 = view_s[3];
  assign seg_data_4 = view_s[4];
  assign seg_data_5 = view_s[5];

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: frame-level reference model compared every cycle,
// plus directed literal checks and randomized update traffic.
module tb_seg_disp_ctrl;

  localparam int HALF = 10;
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [23:0] upd_val = 24'h000000;
  logic [5:0]  upd_dp = 6'b000000;
  logic        upd_lzs = 1'b0;
  logic [5:0]  blink_mask = 6'b000000;
  logic [7:0]  seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5;
  logic [7:0]  seg_s [6];

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          busy = 0;
  int          ticks = 0;
  logic [47:0] m_disp = 48'hFFFF_FFFF_FFFF;
  logic [47:0] m_pend = 48'hFFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  seg_disp_ctrl #(.CLK_FREQ(20), .BLINK_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_val(upd_val), .upd_dp(upd_dp), .upd_lzs(upd_lzs), .blink_mask(blink_mask),
    .seg_data_0(seg_data_0), .seg_data_1(seg_data_1), .seg_data_2(seg_data_2),
    .seg_data_3(seg_data_3), .seg_data_4(seg_data_4), .seg_data_5(seg_data_5)
  );

  assign seg_s[0] = seg_data_0;
  assign seg_s[1] = seg_data_1;
  assign seg_s[2] = seg_data_2;
  assign seg_s[3] = seg_data_3;
  assign seg_s[4] = seg_data_4;
  assign seg_s[5] = seg_data_5;

  // Whole-frame encoding: scan from the most significant digit, blank zeros until something significant.
  function automatic logic [47:0] frame(input logic [23:0] v, input logic [5:0] dp, input logic lzs);
    logic [47:0] f;
    logic [3:0]  n;
    logic [7:0]  g;
    bit          lead;
    lead = 1'b1;
    f = 48'h0;
    for (int i = 5; i >= 0; i--) begin
      n = v[i*4 +: 4];
      g = GLYPH[n];
      if (lzs && lead && n == 4'h0 && !dp[i] && i != 0) begin
        f[i*8 +: 8] = 8'hFF;
      end else begin
        f[i*8 +: 8] = {~dp[i], g[6:0]};
        lead = 1'b0;
      end
    end
    return f;
  endfunction

  function automatic logic [7:0] exp_seg(input int i);
    logic [7:0] e;
    e = m_disp[i*8 +: 8];
`ifdef SEG_DISP_CTRL_BLINK_EN
    if (((ticks / HALF) % 2) == 1 && blink_mask[i]) e = 8'hFF;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [47:0] exp, input logic exp_rdy);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_seg%0d", name, i), seg_s[i], exp[i*8 +: 8]);
    chk({name, "_ready"}, {7'd0, upd_ready}, {7'd0, exp_rdy});
  endtask

  // Model: a transfer becomes visible 7 edges later; ready while no update is in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 0;
      ticks  <= 0;
      m_disp <= 48'hFFFF_FFFF_FFFF;
    end else begin
      ticks <= ticks + 1;
      if (busy != 0) begin
        busy <= busy - 1;
        if (busy == 1) m_disp <= m_pend;
      end else if (upd_valid) begin
        m_pend <= frame(upd_val, upd_dp, upd_lzs);
        busy   <= 7;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) chk($sformatf("model_seg%0d", i), seg_s[i], exp_seg(i));
    chk("model_ready", {7'd0, upd_ready}, {7'd0, (busy == 0)});
  end

  task automatic send(input logic [23:0] v, input logic [5:0] d, input logic l);
    @(posedge clk);
    #2;
    upd_valid = 1'b1; upd_val = v; upd_dp = d; upd_lzs = l;
    @(posedge clk);
    #2;
    upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_frame("reset", 48'hFFFF_FFFF_FFFF, 1'b1);

    // 012345 with suppression: unchanged at N+6, new frame at N+7
    send(24'h012345, 6'b000000, 1'b1);
    repeat (6) @(posedge clk);
    #1 chk_frame("lat_n6", 48'hFFFF_FFFF_FFFF, 1'b0);
    @(posedge clk);
    #1 chk_frame("lzs_012345", 48'hFF_F9_A4_B0_99_92, 1'b1);

    // All zeros with dp on digit 2 stops suppression there
    send(24'h000000, 6'b000100, 1'b1);
    repeat (7) @(posedge clk);
    #1 chk_frame("lzs_dp", 48'hFF_FF_FF_40_C0_C0, 1'b1);

    // Second request held during CONV is only accepted once ready returns
    @(posedge clk);
    #2 upd_valid = 1'b1; upd_val = 24'h000001; upd_dp = 6'b000000; upd_lzs = 1'b1;
    @(posedge clk);
    #2 upd_val = 24'hFFFFFF;
    repeat (7) @(posedge clk);
    #1 chk_frame("hold_first", 48'hFF_FF_FF_FF_FF_F9, 1'b1);
    @(posedge clk);
    #2 upd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk_frame("hold_second", 48'h8E_8E_8E_8E_8E_8E, 1'b1);

    // Randomized traffic, zero-biased nibbles, random blink masks
    for (int k = 0; k < 800; k++) begin
      @(posedge clk);
      #2;
      upd_valid = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 6; j++)
        upd_val[j*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      upd_dp     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000;
      upd_lzs    = 1'($urandom_range(0, 1));
      blink_mask = 6'($urandom);
    end
    @(posedge clk);
    #2 upd_valid = 1'b0;
    repeat (10) @(posedge clk);

    // Blink on digit 0 only over several half-periods
    #2 blink_mask = 6'b000001;
    send(24'h000008, 6'b000000, 1'b0);
    repeat (45) @(posedge clk);

    // Reset in the middle of an update aborts it
    #2 blink_mask = 6'b000000;
    send(24'h111111, 6'b000000, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_frame("abort_now", 48'hFFFF_FFFF_FFFF, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk_frame("abort_after", 48'hFFFF_FFFF_FFFF, 1'b1);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
